// File: rtl/folded_hist_reg_pkg.sv
// Shared BPU defines: default history/fold sizes, checkpoint depth
// and checkpoint entry layout {ghr, idx_fold, tag_fold}.
package folded_hist_reg_pkg;

  localparam int FHR_HIST_LEN   = 16;
  localparam int FHR_IDX_W      = 7;
  localparam int FHR_TAG_W      = 8;
  localparam int FHR_CKPT_DEPTH = 4;

  function automatic int ckpt_w(
    input int h,
    input int i,
    input int t
  );
    return h + i + t;
  endfunction

endpackage

// File: rtl/folded_hist_reg_fold.sv
// hist_fold_comb: combinational XOR fold of an N-bit vector to W bits.
// Ports: vec (N bits in), fold (W bits out).
module hist_fold_comb #(
  parameter int N = 16,
  parameter int W = 7
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] fold
);

  always_comb begin
    fold = '0;
    for (int i = 0; i < N; i++)
      fold[i % W] = fold[i % W] ^ vec[i];
  end

endmodule

// File: rtl/folded_hist_reg.sv
// Speculative GHR with O(1) index/tag folds and checkpoint restore.
// Ports: push/commit/restore controls in; ghr/folds/ckpt_id/ready out.
// Optional self-check of folds: define BPU_FHR_SELFCHECK_EN.
module folded_hist_reg
  import folded_hist_reg_pkg::*;
#(
  parameter int HIST_LENGTH = FHR_HIST_LEN,
  parameter int IDX_WIDTH   = FHR_IDX_W,
  parameter int TAG_WIDTH   = FHR_TAG_W,
  parameter int CKPT_DEPTH  = FHR_CKPT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid_i,
  input  logic                          push_taken_i,
  output logic                          push_ready_o,
  output logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id_o,
  input  logic                          commit_valid_i,
  input  logic                          restore_valid_i,
  input  logic [$clog2(CKPT_DEPTH)-1:0] restore_id_i,
  input  logic                          restore_taken_i,
  output logic [HIST_LENGTH-1:0]        ghr_o,
  output logic [IDX_WIDTH-1:0]          idx_fold_o,
  output logic [TAG_WIDTH-1:0]          tag_fold_o,
  output logic                          fold_err_o
);

  localparam int PW = $clog2(CKPT_DEPTH);
  localparam int EW = ckpt_w(HIST_LENGTH, IDX_WIDTH, TAG_WIDTH);

  typedef logic [PW:0] ptr_t;

  logic [HIST_LENGTH-1:0] ghr_q, ghr_b, ghr_n;
  logic [IDX_WIDTH-1:0]   idx_q, idx_b, idx_n;
  logic [TAG_WIDTH-1:0]   tag_q, tag_b, tag_n;
  ptr_t                   head_q, tail_q, head_n, tail_n;
  ptr_t                   count;
  logic [PW-1:0]          off;
  logic                   push_ok, rest_ok, commit_ok;
  logic                   bit_in;
  logic [EW-1:0]          mem [CKPT_DEPTH];

  function automatic logic [IDX_WIDTH-1:0] shift_idx(
    input logic [IDX_WIDTH-1:0] f,
    input logic                 b,
    input logic                 msb
  );
    logic [IDX_WIDTH-1:0] r;
    r = {f[IDX_WIDTH-2:0], f[IDX_WIDTH-1]};
    r[0] = r[0] ^ b;
    r[HIST_LENGTH % IDX_WIDTH] = r[HIST_LENGTH % IDX_WIDTH] ^ msb;
    return r;
  endfunction

  function automatic logic [TAG_WIDTH-1:0] shift_tag(
    input logic [TAG_WIDTH-1:0] f,
    input logic                 b,
    input logic                 msb
  );
    logic [TAG_WIDTH-1:0] r;
    r = {f[TAG_WIDTH-2:0], f[TAG_WIDTH-1]};
    r[0] = r[0] ^ b;
    r[HIST_LENGTH % TAG_WIDTH] = r[HIST_LENGTH % TAG_WIDTH] ^ msb;
    return r;
  endfunction

  assign count        = tail_q - head_q;
  assign push_ready_o = (count != ptr_t'(CKPT_DEPTH));
  assign ckpt_id_o    = tail_q[PW-1:0];

  // Distance of the restore slot from the oldest live entry.
  assign off       = restore_id_i - head_q[PW-1:0];
  assign rest_ok   = restore_valid_i && ({1'b0, off} < count);
  assign push_ok   = push_valid_i && push_ready_o && !restore_valid_i;
  assign commit_ok = commit_valid_i && (count != '0);

  always_comb begin
    {ghr_b, idx_b, tag_b} = {ghr_q, idx_q, tag_q};
    bit_in = push_taken_i;
    tail_n = tail_q;
    if (rest_ok) begin
      {ghr_b, idx_b, tag_b} = mem[restore_id_i];
      bit_in = restore_taken_i;
      tail_n = head_q + ptr_t'(off) + ptr_t'(1);
    end else if (push_ok) begin
      tail_n = tail_q + ptr_t'(1);
    end
    head_n = head_q + (commit_ok ? ptr_t'(1) : ptr_t'(0));
    ghr_n  = ghr_q;
    idx_n  = idx_q;
    tag_n  = tag_q;
    if (rest_ok || push_ok) begin
      ghr_n = {ghr_b[HIST_LENGTH-2:0], bit_in};
      idx_n = shift_idx(idx_b, bit_in, ghr_b[HIST_LENGTH-1]);
      tag_n = shift_tag(tag_b, bit_in, ghr_b[HIST_LENGTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q  <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ghr_q  <= ghr_n;
      idx_q  <= idx_n;
      tag_q  <= tag_n;
      head_q <= head_n;
      tail_q <= tail_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst)
      mem[tail_q[PW-1:0]] <= {ghr_q, idx_q, tag_q};
  end

  assign ghr_o      = ghr_q;
  assign idx_fold_o = idx_q;
  assign tag_fold_o = tag_q;

`ifdef BPU_FHR_SELFCHECK_EN
  logic [IDX_WIDTH-1:0] idx_calc;
  logic [TAG_WIDTH-1:0] tag_calc;
  logic                 err_q;

  hist_fold_comb #(.N(HIST_LENGTH), .W(IDX_WIDTH)) u_idx_chk (
    .vec  (ghr_q),
    .fold (idx_calc)
  );

  hist_fold_comb #(.N(HIST_LENGTH), .W(TAG_WIDTH)) u_tag_chk (
    .vec  (ghr_q),
    .fold (tag_calc)
  );

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((idx_calc != idx_q) || (tag_calc != tag_q))
      err_q <= 1'b1;
  end

  assign fold_err_o = err_q;
`else
  assign fold_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_folded_hist_reg.sv
// Scoreboard bench for folded_hist_reg: directed plan + random traffic
// against a queue-based history/checkpoint reference model.
module tb_folded_hist_reg;

  localparam int H = 16;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid_i, push_taken_i, push_ready_o;
  logic [1:0]  ckpt_id_o;
  logic        commit_valid_i, restore_valid_i, restore_taken_i;
  logic [1:0]  restore_id_i;
  logic [15:0] ghr_o;
  logic [6:0]  idx_fold_o;
  logic [7:0]  tag_fold_o;
  logic        fold_err_o;

  always #5 clk = ~clk;

  folded_hist_reg dut (
    .clk             (clk),
    .rst             (rst),
    .push_valid_i    (push_valid_i),
    .push_taken_i    (push_taken_i),
    .push_ready_o    (push_ready_o),
    .ckpt_id_o       (ckpt_id_o),
    .commit_valid_i  (commit_valid_i),
    .restore_valid_i (restore_valid_i),
    .restore_id_i    (restore_id_i),
    .restore_taken_i (restore_taken_i),
    .ghr_o           (ghr_o),
    .idx_fold_o      (idx_fold_o),
    .tag_fold_o      (tag_fold_o),
    .fold_err_o      (fold_err_o)
  );

  typedef struct {
    logic [15:0] ghr;
    logic [6:0]  idx;
    logic [7:0]  tag;
    logic        rdy;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;

  logic [15:0] m_ghr;
  logic [15:0] m_q[$];
  int          m_head;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [15:0] g, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < H; i++) r[i % w] = r[i % w] ^ g[i];
    return r;
  endfunction

  task automatic step(input bit r, input bit pv, input bit pt,
                      input bit cv, input bit rv, input int rid,
                      input bit rt);
    exp_t e;
    int   sz, k;
    bit   cok, rok;
    rst = r;
    push_valid_i = pv;
    push_taken_i = pt;
    commit_valid_i = cv;
    restore_valid_i = rv;
    restore_id_i = 2'(rid);
    restore_taken_i = rt;
    if (r) begin
      m_ghr = '0;
      m_q.delete();
      m_head = 0;
    end else begin
      sz  = m_q.size();
      cok = cv && sz > 0;
      k   = (rid - m_head + D) % D;
      rok = rv && k < sz;
      if (rok) begin
        m_ghr = m_q[k];
        while (m_q.size() > k + 1) void'(m_q.pop_back());
        m_ghr = {m_ghr[14:0], rt};
      end else if (pv && sz != D && !rv) begin
        m_q.push_back(m_ghr);
        m_ghr = {m_ghr[14:0], pt};
      end
      if (cok) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % D;
      end
    end
    e.ghr = m_ghr;
    e.idx = fold(m_ghr, 7)[6:0];
    e.tag = fold(m_ghr, 8);
    e.rdy = (m_q.size() != D);
    e.id  = 2'((m_head + m_q.size()) % D);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic push(input bit t);
    step(0, 1, t, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ghr", 32'(ghr_o), 32'(e.ghr));
        chk("idx_fold", 32'(idx_fold_o), 32'(e.idx));
        chk("tag_fold", 32'(tag_fold_o), 32'(e.tag));
        chk("push_ready", 32'(push_ready_o), 32'(e.rdy));
        chk("ckpt_id", 32'(ckpt_id_o), 32'(e.id));
        chk("fold_err", 32'(fold_err_o), 32'd0);
      end
    end
  end

  initial begin : driver
    logic [15:0] g;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ckpt_id", 32'(ckpt_id_o), 32'd0);
    chk("rst_ready", 32'(push_ready_o), 32'd1);
    push(1);
    chk("single_ghr", 32'(ghr_o), 32'h1);
    chk("single_idx", 32'(idx_fold_o), 32'h1);
    chk("single_tag", 32'(tag_fold_o), 32'h1);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 1, 0, 0, 0);
    chk("sat_ghr", 32'(ghr_o), 32'hFFFF);
    chk("sat_idx", 32'(idx_fold_o), 32'h03);
    chk("sat_tag", 32'(tag_fold_o), 32'h00);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(1'($urandom));
    chk("full_ready", 32'(push_ready_o), 32'd0);
    g = ghr_o;
    push(1);
    chk("full_drop", 32'(ghr_o), 32'(g));
    step(0, 0, 0, 1, 0, 0, 0);
    chk("commit_ready", 32'(push_ready_o), 32'd1);
    push(0);
    g = ghr_o;
    step(0, 1, 1, 1, 0, 0, 0);
    chk("full_commit_drop", 32'(ghr_o), 32'(g));

    step(1, 0, 0, 0, 0, 0, 0);
    push(1); push(0); push(1); push(1);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("rest_ghr", 32'(ghr_o), 32'h3);
    chk("rest_idx", 32'(idx_fold_o), 32'h3);
    chk("rest_id", 32'(ckpt_id_o), 32'd2);
    step(0, 0, 0, 0, 1, 3, 0);
    chk("rest_outside", 32'(ghr_o), 32'h3);
    step(0, 1, 0, 0, 1, 1, 0);
    chk("rest_beats_push", 32'(ckpt_id_o), 32'd2);

    step(1, 0, 0, 0, 0, 0, 0);
    push(1); push(1); push(1);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("midrst_ghr", 32'(ghr_o), 32'd0);
    chk("midrst_ready", 32'(push_ready_o), 32'd1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 60,
           1'($urandom), $urandom_range(99) < 30,
           $urandom_range(99) < 15, int'($urandom_range(3)),
           1'($urandom));

    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
